// File: rtl/trace_checker_pkg.sv
// Shared definitions for the commit-trace checker: FSM encoding, golden/commit
// record layout and the record equality helper.
package trace_checker_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READY = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    localparam int REC_W = 64;

    // pc occupies the upper word so a record reads naturally as {pc, inst}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } rec_t;

    function automatic logic rec_equal(input rec_t a, input rec_t b);
        return (a.pc == b.pc) && (a.inst == b.inst);
    endfunction

endpackage

// File: rtl/trace_rec_reg.sv
// Holds the latched golden record and the latched commit record; the equality
// result is registered alongside the commit so it is ready in the compare cycle.
module trace_rec_reg
    import trace_checker_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              gold_load,
    input  logic [31:0]       gold_pc,
    input  logic [31:0]       gold_inst,
    input  logic              commit_load,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_inst,
    output logic [REC_W-1:0]  commit_rec,
    output logic              rec_match
);

    rec_t gold_rec_r;
    rec_t commit_rec_r;
    logic rec_match_r;

    // Record capture and compare
    always_ff @(posedge clk) begin
        if (reset) begin
            gold_rec_r   <= rec_t'({REC_W{1'b0}});
            commit_rec_r <= rec_t'({REC_W{1'b0}});
            rec_match_r  <= 1'b0;
        end else begin
            if (gold_load) begin
                gold_rec_r <= rec_t'({gold_pc, gold_inst});
            end else begin
                gold_rec_r <= gold_rec_r;
            end
            if (commit_load) begin
                commit_rec_r <= rec_t'({commit_pc, commit_inst});
                rec_match_r  <= rec_equal(gold_rec_r, rec_t'({commit_pc, commit_inst}));
            end else begin
                commit_rec_r <= commit_rec_r;
                rec_match_r  <= rec_match_r;
            end
        end
    end

    assign commit_rec = commit_rec_r;
    assign rec_match  = rec_match_r;

endmodule

// File: rtl/trace_checker.sv
// Compares each retired CPU instruction against an external golden trace,
// fetching one golden record ahead of every commit.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W:0]   trace_len,
    input  logic              commit_valid,
    input  logic [31:0]       commit_pc,
    input  logic [31:0]       commit_inst,
    output logic              commit_ready,
    output logic              gold_rd,
    output logic [ADDR_W-1:0] gold_addr,
    input  logic              gold_rvalid,
    input  logic [31:0]       gold_pc,
    input  logic [31:0]       gold_inst,
    output logic [ADDR_W:0]   match_count,
    output logic              mismatch,
    output logic              overrun,
    output logic              done,
    output logic [31:0]       err_pc,
    output logic [31:0]       err_inst
);

    state_t            state_r;
    logic [ADDR_W:0]   trace_len_r;
    logic [ADDR_W:0]   match_count_r;
    logic              gold_rd_r;
    logic [ADDR_W-1:0] gold_addr_r;
    logic              commit_ready_r;
    logic              mismatch_r;
    logic              overrun_r;
    logic              done_r;
    logic [31:0]       err_pc_r;
    logic [31:0]       err_inst_r;

    logic              gold_load_s;
    logic              commit_load_s;
    logic [REC_W-1:0]  commit_rec_s;
    rec_t              held_rec_s;
    logic              rec_match_s;
    logic [ADDR_W:0]   count_inc_s;

    // A commit in WAIT wins over a simultaneous golden response
    assign gold_load_s   = (state_r == ST_WAIT) && gold_rvalid && !commit_valid;
    assign commit_load_s = (state_r == ST_READY) && commit_valid;
    assign held_rec_s    = rec_t'(commit_rec_s);
    assign count_inc_s   = match_count_r + {{ADDR_W{1'b0}}, 1'b1};

    trace_rec_reg u_rec (
        .clk         (clk),
        .reset       (reset),
        .gold_load   (gold_load_s),
        .gold_pc     (gold_pc),
        .gold_inst   (gold_inst),
        .commit_load (commit_load_s),
        .commit_pc   (commit_pc),
        .commit_inst (commit_inst),
        .commit_rec  (commit_rec_s),
        .rec_match   (rec_match_s)
    );

    // Checker FSM. FETCH with gold_rd low only occurs right after reset: that
    // cycle issues the first read (or finishes at once for an empty trace).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_FETCH;
            trace_len_r    <= trace_len;
            match_count_r  <= {(ADDR_W+1){1'b0}};
            gold_rd_r      <= 1'b0;
            gold_addr_r    <= {ADDR_W{1'b0}};
            commit_ready_r <= 1'b0;
            mismatch_r     <= 1'b0;
            overrun_r      <= 1'b0;
            done_r         <= 1'b0;
            err_pc_r       <= 32'h0000_0000;
            err_inst_r     <= 32'h0000_0000;
        end else begin
            gold_rd_r      <= 1'b0;
            commit_ready_r <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (commit_valid) begin
                        overrun_r  <= 1'b1;
                        err_pc_r   <= commit_pc;
                        err_inst_r <= commit_inst;
                        state_r    <= ST_FAIL;
                    end else if (gold_rd_r) begin
                        state_r <= ST_WAIT;
                    end else if (match_count_r == trace_len_r) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        gold_rd_r   <= 1'b1;
                        gold_addr_r <= match_count_r[ADDR_W-1:0];
                    end
                end
                ST_WAIT: begin
                    if (commit_valid) begin
                        overrun_r  <= 1'b1;
                        err_pc_r   <= commit_pc;
                        err_inst_r <= commit_inst;
                        state_r    <= ST_FAIL;
                    end else if (gold_rvalid) begin
                        commit_ready_r <= 1'b1;
                        state_r        <= ST_READY;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_READY: begin
                    if (commit_valid) begin
                        state_r <= ST_CMP;
                    end else begin
                        commit_ready_r <= 1'b1;
                    end
                end
                ST_CMP: begin
                    if (commit_valid) begin
                        overrun_r  <= 1'b1;
                        err_pc_r   <= commit_pc;
                        err_inst_r <= commit_inst;
                        state_r    <= ST_FAIL;
                    end else if (rec_match_s) begin
                        match_count_r <= count_inc_s;
                        if (count_inc_s == trace_len_r) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            gold_rd_r   <= 1'b1;
                            gold_addr_r <= count_inc_s[ADDR_W-1:0];
                            state_r     <= ST_FETCH;
                        end
                    end else begin
                        mismatch_r <= 1'b1;
                        err_pc_r   <= held_rec_s.pc;
                        err_inst_r <= held_rec_s.inst;
                        state_r    <= ST_FAIL;
                    end
                end
                ST_DONE: begin
                    if (commit_valid) begin
                        overrun_r  <= 1'b1;
                        done_r     <= 1'b0;
                        err_pc_r   <= commit_pc;
                        err_inst_r <= commit_inst;
                        state_r    <= ST_FAIL;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_FAIL: begin
                    state_r <= ST_FAIL;
                end
                default: begin
                    state_r <= ST_FAIL;
                end
            endcase
        end
    end

    assign commit_ready = commit_ready_r;
    assign gold_rd      = gold_rd_r;
    assign gold_addr    = gold_addr_r;
    assign match_count  = match_count_r;
    assign mismatch     = mismatch_r;
    assign overrun      = overrun_r;
    assign done         = done_r;
    assign err_pc       = err_pc_r;
    assign err_inst     = err_inst_r;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: golden-memory responder with programmable
// latency plus a linear sequence of commit scenarios with hand-derived results.
module tb_trace_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] trace_len = 14'd0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'h0;
    logic [31:0] commit_inst = 32'h0;
    logic        commit_ready;
    logic        gold_rd;
    logic [12:0] gold_addr;
    logic        gold_rvalid;
    logic [31:0] gold_pc;
    logic [31:0] gold_inst;
    logic [13:0] match_count;
    logic        mismatch;
    logic        overrun;
    logic        done;
    logic [31:0] err_pc;
    logic [31:0] err_inst;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_pc   [0:3];
    logic [31:0] mem_inst [0:3];

    int          lat = 1;
    int          rsp_cnt = 0;
    bit          rsp_pending = 1'b0;
    logic [12:0] rsp_addr = 13'd0;
    logic        rsp_v = 1'b0;
    logic [31:0] rsp_pc = 32'h0;
    logic [31:0] rsp_inst = 32'h0;
    int          rd_cnt = 0;
    int          viol_cnt = 0;
    logic        inj_v = 1'b0;
    logic [31:0] inj_pc = 32'h0;
    logic [31:0] inj_inst = 32'h0;
    int          rd0;
    int          viol0;

    assign gold_rvalid = rsp_v | inj_v;
    assign gold_pc     = inj_v ? inj_pc : rsp_pc;
    assign gold_inst   = inj_v ? inj_inst : rsp_inst;

    trace_checker #(.ADDR_W(13)) dut (
        .clk          (clk),
        .reset        (reset),
        .trace_len    (trace_len),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_ready (commit_ready),
        .gold_rd      (gold_rd),
        .gold_addr    (gold_addr),
        .gold_rvalid  (gold_rvalid),
        .gold_pc      (gold_pc),
        .gold_inst    (gold_inst),
        .match_count  (match_count),
        .mismatch     (mismatch),
        .overrun      (overrun),
        .done         (done),
        .err_pc       (err_pc),
        .err_inst     (err_inst)
    );

    always #5 clk = ~clk;

    // Golden memory: answers a read 'lat' cycles after the gold_rd cycle
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rsp_pending && commit_ready) viol_cnt++;
            rsp_v = 1'b0;
            if (rsp_pending) begin
                if (rsp_cnt == 0) begin
                    rsp_v       = 1'b1;
                    rsp_pc      = mem_pc[rsp_addr[1:0]];
                    rsp_inst    = mem_inst[rsp_addr[1:0]];
                    rsp_pending = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
            if (gold_rd) begin
                rd_cnt++;
                rsp_pending = 1'b1;
                rsp_addr    = gold_addr;
                rsp_cnt     = lat - 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset(input logic [13:0] len);
        reset     = 1'b1;
        trace_len = len;
        tick();
        tick();
        chk("rst_flags", 64'({gold_rd, commit_ready, mismatch, overrun, done}), 64'd0);
        chk("rst_count", 64'(match_count), 64'd0);
        chk("rst_err", {err_pc, err_inst}, 64'd0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        tick();
        chk("first_rd", 64'({gold_rd, gold_addr}), 64'({1'b1, 13'd0}));
    endtask

    task automatic do_commit(input logic [31:0] pc, input logic [31:0] inst);
        int n = 0;
        while (!commit_ready && n < 60) begin
            tick();
            n++;
        end
        chk("ready_seen", 64'(commit_ready), 64'd1);
        commit_valid = 1'b1;
        commit_pc    = pc;
        commit_inst  = inst;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        mem_pc[0] = 32'h0040_0000; mem_inst[0] = 32'h3c01_0000;
        mem_pc[1] = 32'h0040_0004; mem_inst[1] = 32'h3424_0080;
        mem_pc[2] = 32'h0040_0008; mem_inst[2] = 32'h2005_0004;
        mem_pc[3] = 32'h0000_0000; mem_inst[3] = 32'h0000_0000;

        // Full match of a three-record trace, 1-cycle golden latency
        lat = 1;
        hold_reset(14'd3);
        rd0 = rd_cnt;
        release_reset();
        do_commit(32'h0040_0000, 32'h3c01_0000);
        do_commit(32'h0040_0004, 32'h3424_0080);
        do_commit(32'h0040_0008, 32'h2005_0004);
        tick();
        chk("s1_count", 64'(match_count), 64'd3);
        chk("s1_flags", 64'({mismatch, overrun, done}), 64'b001);
        idle(6);
        chk("s1_rd_total", 64'(rd_cnt - rd0), 64'd3);
        chk("s1_done_hold", 64'(done), 64'd1);

        // Instruction mismatch on the second commit
        hold_reset(14'd3);
        rd0 = rd_cnt;
        release_reset();
        do_commit(32'h0040_0000, 32'h3c01_0000);
        do_commit(32'h0040_0004, 32'h3424_0081);
        tick();
        chk("s2_flags", 64'({mismatch, overrun, done}), 64'b100);
        chk("s2_err", {err_pc, err_inst}, 64'h0040_0004_3424_0081);
        chk("s2_count", 64'(match_count), 64'd1);
        idle(6);
        chk("s2_rd_total", 64'(rd_cnt - rd0), 64'd2);

        // Commit in the cycle after gold_rd
        hold_reset(14'd3);
        rd0 = rd_cnt;
        release_reset();
        tick();
        commit_valid = 1'b1;
        commit_pc    = 32'h1111_1111;
        commit_inst  = 32'h2222_2222;
        tick();
        commit_valid = 1'b0;
        chk("s3_flags", 64'({mismatch, overrun, done}), 64'b010);
        chk("s3_err", {err_pc, err_inst}, 64'h1111_1111_2222_2222);
        idle(6);
        chk("s3_count", 64'(match_count), 64'd0);
        chk("s3_ready", 64'(commit_ready), 64'd0);
        chk("s3_rd_total", 64'(rd_cnt - rd0), 64'd1);

        // Extra commit after a two-record trace completes
        hold_reset(14'd2);
        release_reset();
        do_commit(32'h0040_0000, 32'h3c01_0000);
        do_commit(32'h0040_0004, 32'h3424_0080);
        tick();
        chk("s4_done", 64'({done, match_count}), 64'({1'b1, 14'd2}));
        commit_valid = 1'b1;
        commit_pc    = 32'h0040_0008;
        commit_inst  = 32'h2005_0004;
        tick();
        commit_valid = 1'b0;
        chk("s4_flags", 64'({mismatch, overrun, done}), 64'b010);
        chk("s4_err", {err_pc, err_inst}, 64'h0040_0008_2005_0004);
        chk("s4_count", 64'(match_count), 64'd2);

        // Five-cycle golden latency, commits only when ready
        lat = 5;
        hold_reset(14'd3);
        viol0 = viol_cnt;
        release_reset();
        do_commit(32'h0040_0000, 32'h3c01_0000);
        do_commit(32'h0040_0004, 32'h3424_0080);
        do_commit(32'h0040_0008, 32'h2005_0004);
        tick();
        chk("s5_count", 64'(match_count), 64'd3);
        chk("s5_flags", 64'({mismatch, overrun, done}), 64'b001);
        chk("s5_ready_in_wait", 64'(viol_cnt - viol0), 64'd0);

        // Reset pulsed during WAIT with a stale response arriving afterwards
        hold_reset(14'd3);
        release_reset();
        tick();
        tick();
        chk("s6_wait_ready", 64'(commit_ready), 64'd0);
        reset    = 1'b1;
        inj_v    = 1'b1;
        inj_pc   = 32'hdead_beef;
        inj_inst = 32'hbad0_cafe;
        tick();
        reset = 1'b0;
        chk("s6_flags", 64'({gold_rd, commit_ready, mismatch, overrun, done}), 64'd0);
        chk("s6_count", 64'(match_count), 64'd0);
        tick();
        inj_v = 1'b0;
        chk("s6_rd_idx0", 64'({gold_rd, gold_addr}), 64'({1'b1, 13'd0}));
        chk("s6_stale_ready", 64'(commit_ready), 64'd0);
        do_commit(32'h0040_0000, 32'h3c01_0000);
        tick();
        chk("s6_after", 64'({match_count, mismatch, overrun}), 64'({14'd1, 1'b0, 1'b0}));

        // Empty trace finishes at once without any golden read
        lat = 1;
        reset     = 1'b1;
        trace_len = 14'd0;
        tick();
        tick();
        rd0 = rd_cnt;
        reset = 1'b0;
        tick();
        chk("s7_done", 64'({done, gold_rd}), 64'b10);
        idle(4);
        chk("s7_rd_total", 64'(rd_cnt - rd0), 64'd0);
        chk("s7_done_hold", 64'({done, match_count}), 64'({1'b1, 14'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
